if_stage: RTL and testbench

Instruction-fetch stage of the RISC-V pipeline. Holds the program counter, reads a word-addressed on-chip instruction memory, and registers `{pc, instruction}` into the IF/ID pipeline register consumed by the decode/register-file stage. It also supports stall, branch redirect with flush, and a synchronous program-load write port. Sits directly upstream of ID: `pc_out`/`instruction_out` drive ID's `pc_recieve`/`instruction_recieve`.

---
 rtl/if_stage.sv | 96 +++++++++
 tb/tb_if_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, word-addressed instruction memory with a
// program-load write port, and the IF/ID pipeline register with stall/branch-flush.
module if_stage #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH),
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [31:0] NOP        = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [63:0]       branch_target,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [31:0]       imem_wdata,
    output logic [63:0]       fetch_pc,
    output logic [63:0]       pc_out,
    output logic [31:0]       instruction_out,
    output logic              valid_out,
    output logic              fetch_fault
);

    logic [31:0]       mem [IMEM_DEPTH];

    logic [63:0]       pc_q, pc_d;
    logic [63:0]       pc_out_q, pc_out_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;

    logic [ADDR_W-1:0] rd_idx;
    logic              in_range;
    logic [31:0]       fetch_word;

    assign rd_idx     = pc_q[ADDR_W+1:2];
    assign in_range   = (pc_q[63:ADDR_W+2] == '0);
    assign fetch_word = in_range ? mem[rd_idx] : NOP;

    // The read above is combinational, so a same-edge write is seen one cycle later.
    always_ff @(posedge clk) begin
        if (imem_we && rst_n) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        fault_d  = fault_q;

        if (branch_taken) begin
            // Redirect wins over stall; the slot being fetched becomes a bubble.
            pc_d     = {branch_target[63:2], 2'b00};
            pc_out_d = pc_q;
            instr_d  = NOP;
            valid_d  = 1'b0;
            if (branch_target[1:0] != 2'b00) begin
                fault_d = 1'b1;
            end
        end else if (!stall) begin
            pc_out_d = pc_q;
            instr_d  = fetch_word;
            valid_d  = in_range;
            pc_d     = pc_q + 64'd4;
            if (!in_range) begin
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            pc_out_q <= 64'h0;
            instr_q  <= NOP;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
        end
    end

    assign fetch_pc        = pc_q;
    assign pc_out          = pc_out_q;
    assign instruction_out = instr_q;
    assign valid_out       = valid_q;
    assign fetch_fault     = fault_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard testbench for if_stage: a behavioural fetch model predicts the
// state after every clock edge, and a monitor compares it one step after the edge.
module tb_if_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 256;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [63:0] fetch_pc;
    logic [63:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;
    logic        fetch_fault;

    if_stage #(
        .IMEM_DEPTH (256),
        .ADDR_W     (8),
        .RESET_PC   (64'h0),
        .NOP        (NOP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_we         (imem_we),
        .imem_waddr      (imem_waddr),
        .imem_wdata      (imem_wdata),
        .fetch_pc        (fetch_pc),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out),
        .fetch_fault     (fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] fpc;
        logic [63:0] pco;
        logic [31:0] ins;
        logic        v;
        logic        f;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state: architectural view of the fetch stage.
    logic [63:0] m_pc;
    logic [63:0] m_pc_out;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_fault;
    logic [31:0] m_mem [DEPTH];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_pc     = 64'h0;
        m_pc_out = 64'h0;
        m_instr  = NOP;
        m_valid  = 1'b0;
        m_fault  = 1'b0;
    endtask

    // One clock edge of the fetch stage described in plain terms.
    task automatic modelStep(input logic st, input logic br, input logic [63:0] tgt,
                             input logic we, input logic [7:0] wa, input logic [31:0] wd);
        logic        inr;
        logic [31:0] word;
        inr  = (m_pc < 64'd1024);
        word = inr ? m_mem[int'((m_pc / 64'd4) % 64'd256)] : NOP;
        if (br) begin
            m_pc_out = m_pc;
            m_instr  = NOP;
            m_valid  = 1'b0;
            if (tgt % 64'd4 != 64'd0) m_fault = 1'b1;
            m_pc = tgt - (tgt % 64'd4);
        end else if (!st) begin
            m_pc_out = m_pc;
            m_instr  = word;
            m_valid  = inr;
            if (!inr) m_fault = 1'b1;
            m_pc = m_pc + 64'd4;
        end
        if (we) m_mem[int'(wa)] = wd;
    endtask

    // Drive one cycle from a negedge, record the prediction, and wait to the next negedge.
    task automatic applyStimulus(input logic st, input logic br, input logic [63:0] tgt,
                                 input logic we, input logic [7:0] wa, input logic [31:0] wd);
        exp_t e;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        imem_we       = we;
        imem_waddr    = wa;
        imem_wdata    = wd;
        modelStep(st, br, tgt, we, wa, wd);
        e.fpc = m_pc;
        e.pco = m_pc_out;
        e.ins = m_instr;
        e.v   = m_valid;
        e.f   = m_fault;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 8'h0, 32'h0);
    endtask

    task automatic branchTo(input logic [63:0] tgt, input logic st);
        applyStimulus(st, 1'b1, tgt, 1'b0, 8'h0, 32'h0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_fetch_pc"}, fetch_pc, 64'h0);
        checkOutput({tag, "_pc_out"}, pc_out, 64'h0);
        checkOutput({tag, "_instr"}, {32'h0, instruction_out}, {32'h0, NOP});
        checkOutput({tag, "_valid"}, {63'h0, valid_out}, 64'h0);
        checkOutput({tag, "_fault"}, {63'h0, fetch_fault}, 64'h0);
    endtask

    // Asynchronous reset taken mid-cycle; a write attempted during reset must be ignored.
    task automatic doReset(input string tag);
        #3;
        rst_n        = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        imem_we      = 1'b1;
        imem_waddr   = 8'd5;
        imem_wdata   = 32'hBAD0_0005;
        #1;
        checkResetValues(tag);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        imem_we = 1'b0;
        rst_n   = 1'b1;
    endtask

    // Monitor: compare one prediction per edge, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("fetch_pc", fetch_pc, e.fpc);
            checkOutput("pc_out", pc_out, e.pco);
            checkOutput("instruction_out", {32'h0, instruction_out}, {32'h0, e.ins});
            checkOutput("valid_out", {63'h0, valid_out}, {63'h0, e.v});
            checkOutput("fetch_fault", {63'h0, fetch_fault}, {63'h0, e.f});
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic [63:0] tgt;
        int          r;

        rst_n         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        imem_we       = 1'b0;
        imem_waddr    = 8'h0;
        imem_wdata    = 32'h0;
        modelReset();

        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Program load with the pipeline stalled.
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0:       w = 32'h0050_0093;
                1:       w = 32'h00A0_0113;
                2:       w = 32'h0020_81B3;
                3:       w = 32'h0000_0333;
                5:       w = 32'h0000_0555;
                16:      w = 32'h0000_1111;
                default: w = $urandom;
            endcase
            applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 8'(i), w);
        end

        doReset("rst1");

        step();
        checkOutput("c1_pc_out", pc_out, 64'h0);
        checkOutput("c1_instr", {32'h0, instruction_out}, 64'h0050_0093);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 8'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 8'h0, 32'h0);
        checkOutput("stall_hold_pc_out", pc_out, 64'h0);
        checkOutput("stall_hold_fetch_pc", fetch_pc, 64'h4);
        step();
        step();
        checkOutput("c3_pc_out", pc_out, 64'h8);
        checkOutput("c3_instr", {32'h0, instruction_out}, 64'h0020_81B3);
        checkOutput("c3_fetch_pc", fetch_pc, 64'd12);

        // Branch under stall: bubble, then the target word.
        branchTo(64'h8, 1'b0);
        branchTo(64'h40, 1'b1);
        checkOutput("br_bubble_instr", {32'h0, instruction_out}, {32'h0, NOP});
        checkOutput("br_bubble_valid", {63'h0, valid_out}, 64'h0);
        step();
        checkOutput("br_target_pc", pc_out, 64'h40);
        checkOutput("br_target_instr", {32'h0, instruction_out}, 64'h0000_1111);

        // Same-edge write/read of index 3 returns the old word, then the new one.
        branchTo(64'd12, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 8'd3, 32'hDEAD_BEEF);
        checkOutput("wr_same_edge_old", {32'h0, instruction_out}, 64'h0000_0333);
        branchTo(64'd12, 1'b0);
        step();
        checkOutput("wr_new_word", {32'h0, instruction_out}, 64'hDEAD_BEEF);

        // Write blocked during reset: index 5 keeps its loaded word.
        branchTo(64'd20, 1'b0);
        step();
        checkOutput("reset_blocks_write", {32'h0, instruction_out}, 64'h0000_0555);

        // Out-of-range fetch, then reset mid-run.
        branchTo(64'h400, 1'b0);
        step();
        checkOutput("oor_valid", {63'h0, valid_out}, 64'h0);
        checkOutput("oor_fault", {63'h0, fetch_fault}, 64'h1);
        step();
        doReset("rst2");
        step();

        // Misaligned target: sticky fault, low bits dropped.
        branchTo(64'h42, 1'b0);
        checkOutput("misalign_fetch_pc", fetch_pc, 64'h40);
        checkOutput("misalign_fault", {63'h0, fetch_fault}, 64'h1);
        step();
        step();
        checkOutput("misalign_fault_sticky", {63'h0, fetch_fault}, 64'h1);

        // PC wrap at 2^64.
        branchTo(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        step();
        checkOutput("wrap_fetch_pc", fetch_pc, 64'h0);

        doReset("rst3");

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                7:       tgt = {54'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
                8:       tgt = 64'h400 + 64'({$urandom_range(0, 63), 2'b00});
                9:       tgt = 64'hFFFF_FFFF_FFFF_FFF8;
                default: tgt = {54'h0, 8'($urandom_range(0, 255)), 2'b00};
            endcase
            applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 99) < 15), tgt,
                          ($urandom_range(0, 9) < 3), 8'($urandom_range(0, 255)), $urandom);
            if (n == 300) doReset("rst_rand");
        end

        step();
        @(negedge clk);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
